hamming_rx_sequencer: RTL
=========================

# hamming_rx_sequencer

Sequences the Hamming(7,4) pair decoder in the receive path. Accepts 16-bit codewords from the line receiver over a valid/ready handshake and drives the decoder's `code_in`/`decode_enable`. It then captures the registered 8-bit result and presents it downstream on a second valid/ready handshake. It also tracks frame boundaries and, optionally, counts codewords with a nonzero syndrome.

## Interface
- `FRAME_LEN`, default 4: decoded bytes per frame, range 1..255.
- `clk` input, 1: single rising-edge clock.
- `reset` input, 1: synchronous, active-high reset.
- `in_valid` input, 1: receiver holds a codeword.
- `in_data` input, 16: codeword; [15:9] high nibble code, [8:2] low nibble code, [1:0] ignored.
- `in_ready` output, 1: sequencer accepts `in_data` this cycle.
- `dec_code_in` output, 16: to decoder `code_in`.
- `dec_enable` output, 1: to decoder `decode_enable`.
- `dec_code_out` input, 8: from decoder `code_out`, registered by the decoder.
- `out_valid` output, 1: decoded byte available.
- `out_data` output, 8: decoded byte.
- `out_ready` input, 1: sink accepts `out_data`.
- `frame_done` output, 1: one-cycle pulse when the last byte of a frame is accepted.
- `err_count` output, 16: saturating count of words with a correctable error. Exists only with `HRX_ERRCNT_EN`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, OUT. Reset state is IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: latch `in_data` into `code_reg`, go to ISSUE.
- ISSUE:
  - `dec_enable`=1; `dec_code_in`=`code_reg`. The decoder registers its result at the end of this cycle.
  - Always go to WAIT.
- WAIT:
  - Latch `dec_code_out` into `out_data`, go to OUT.
- OUT:
  - `out_valid`=1; `out_data` is held stable until accepted.
  - On `out_ready`: byte is consumed.
    - If `in_valid` is also high, `in_ready`=1, the new word is latched and the FSM goes to ISSUE (back-to-back).
    - Otherwise go to IDLE.
  - `in_ready`=`out_ready` in this state.
- `dec_code_in` always reflects `code_reg`. `dec_enable`=0 in every state except ISSUE.
- Frame counter (8-bit):
  - Increments on each `out_valid & out_ready`.
  - On the acceptance where count == `FRAME_LEN`-1: `frame_done` pulses the following cycle and the count wraps to 0.
- `in_data`/`in_valid` are ignored outside IDLE and outside the accepting OUT case. The receiver must hold its data.

## Timing
- Reset values:
  - state=IDLE, `code_reg`=0, `out_data`=0.
  - `out_valid`=0, `dec_enable`=0, `frame_done`=0.
  - frame count=0, `err_count`=0.
  - `in_ready`=1 in the first cycle after reset.
- Latency, with accept at edge E0:
  - `dec_enable` is high during cycle E0..E1.
  - Decoder output is valid after E1.
  - `out_valid` rises after E2 (3 cycles).
- Throughput: one word per 3 cycles with `out_ready` tied high.
- Back-pressure: `out_valid` stays high and `out_data` stays constant while `out_ready`=0. No word is lost or duplicated.
- Reset mid-operation (any state): in-flight word discarded, no `out_valid`, no `frame_done`, frame count cleared.
- `frame_done` with `FRAME_LEN`=1: pulses after every accepted byte.

## Configuration
- `HRX_ERRCNT_EN` defined:
  - In ISSUE, the block computes both 3-bit syndromes from `code_reg` using the decoder's equations. For the high half c=`code_reg[15:9]`:
    - s2=c6^c5^c4^c2
    - s1=c6^c5^c3^c1
    - s0=c6^c4^c3^c0
  - The low half uses the same equations on c=`code_reg[8:2]`.
  - If either syndrome is nonzero, `err_count` increments by 1, saturating at 0xFFFF.
  - A word with both halves in error counts once.
- `HRX_ERRCNT_EN` undefined: the `err_count` port, syndrome logic and counter are absent. All other behaviour is identical.

## Test plan
- Clean word: reset, then `in_data`=0xB364 with `out_ready`=1 → `dec_enable` pulses 1 cycle, `out_data`=0xBB with `out_valid` 3 cycles after accept, `err_count`=0.
- Single-bit error: `in_data`=0x3364 (bit 15 flipped) → `out_data`=0xBB, `err_count`=1. Then 0x3324 (bits 15 and 6 flipped) → `out_data`=0xBB, `err_count`=2.
- Back-pressure: `out_ready`=0 for 10 cycles after `out_valid` → `out_data` stable, `in_ready`=0, `dec_enable` stays 0. Release → byte accepted once and the next word is accepted in the same cycle.
- Frame: `FRAME_LEN`=4, 9 words streamed with `out_ready`=1 → `frame_done` pulses exactly after bytes 4 and 8, and the count is 1 at the end.
- Reset in WAIT: assert `reset` the cycle after `dec_enable` → no `out_valid`, `in_ready`=1 next cycle, frame count 0.
- Saturation (`HRX_ERRCNT_EN`): preload via 65536+ erroneous words, or force the counter to 0xFFFE, then send 3 erroneous words → `err_count` holds at 0xFFFF.

Source files
------------

// File: rtl/hamming_rx_sequencer.sv
// Receive-path sequencer for the Hamming(7,4) pair decoder.
// Optional syndrome error counter enabled by defining HRX_ERRCNT_EN.
module hamming_rx_sequencer #(
    parameter int unsigned FRAME_LEN = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic [15:0] dec_code_in,
    output logic        dec_enable,
    input  logic [7:0]  dec_code_out,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        frame_done
`ifdef HRX_ERRCNT_EN
    ,
    output logic [15:0] err_count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        OUT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] code_reg;
    logic [7:0]  frame_cnt;
    logic        accept_in;
    logic        accept_out;
    logic        last_byte;

    assign accept_in   = in_valid & in_ready;
    assign accept_out  = out_valid & out_ready;
    assign last_byte   = (frame_cnt == 8'(FRAME_LEN - 1));
    assign dec_code_in = code_reg;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and handshake/decoder strobes
    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        dec_enable = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = ISSUE;
            end
            ISSUE: begin
                dec_enable = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT: begin
                state_nxt = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_nxt = in_valid ? ISSUE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Codeword capture on accept, decoded byte capture one cycle after issue
    always_ff @(posedge clk) begin
        if (reset) begin
            code_reg <= '0;
            out_data <= '0;
        end else begin
            if (accept_in) code_reg <= in_data;
            if (state == WAIT) out_data <= dec_code_out;
        end
    end

    // Byte counter within a frame; pulse after the last byte is taken
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= accept_out & last_byte;
            if (accept_out) frame_cnt <= last_byte ? 8'd0 : frame_cnt + 8'd1;
        end
    end

`ifdef HRX_ERRCNT_EN
    function automatic logic [2:0] syndrome(input logic [6:0] c);
        return {c[6] ^ c[5] ^ c[4] ^ c[2],
                c[6] ^ c[5] ^ c[3] ^ c[1],
                c[6] ^ c[4] ^ c[3] ^ c[0]};
    endfunction

    logic [2:0]  syn_hi;
    logic [2:0]  syn_lo;
    logic        has_err;
    logic [15:0] err_cnt;

    assign syn_hi    = syndrome(code_reg[15:9]);
    assign syn_lo    = syndrome(code_reg[8:2]);
    assign has_err   = (|syn_hi) | (|syn_lo);
    assign err_count = err_cnt;

    // Saturating count of words with any nonzero syndrome, one per word
    always_ff @(posedge clk) begin
        if (reset)
            err_cnt <= '0;
        else if (state == ISSUE && has_err && err_cnt != 16'hFFFF)
            err_cnt <= err_cnt + 16'd1;
    end
`endif

endmodule
